// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux_rr slice: mode encodings and the
// one-hot to index helper used by the arbiter.
package stream_mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Widest one-hot vector the helper accepts; callers zero-extend into it.
    localparam int MAX_CH = 32;

    // OR-reduction encoder: correct for one-hot or all-zero inputs, which is
    // all the arbiter ever produces.
    function automatic int unsigned onehot_to_idx(input logic [MAX_CH-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter. Searches req starting at ptr and
// wrapping modulo N; grants the first requester when en is high.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N     = 5,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] gnt_idx
);

    logic [SEL_W:0]   idx_w;
    logic [SEL_W-1:0] idx;
    logic             found;

    // Walk ptr, ptr+1, ... wrapping at N; first active request wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx_w = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx_w = {1'b0, ptr} + (SEL_W+1)'(k);
            if (idx_w >= (SEL_W+1)'(N)) begin
                idx_w = idx_w - (SEL_W+1)'(N);
            end
            idx = idx_w[SEL_W-1:0];
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Index of the granted channel (0 when nothing is granted).
    always_comb begin
        gnt_idx = SEL_W'(onehot_to_idx(MAX_CH'(gnt)));
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with round-robin or fixed-select
// arbitration and a registered output stage (one cycle latency).
// Optional packet lock is built when STREAM_MUX_PKT_LOCK_EN is defined: a
// channel that starts a multi-beat packet keeps the grant until its last beat.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N     = 5,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] out_sel
`ifdef STREAM_MUX_PKT_LOCK_EN
    ,
    input  logic [N-1:0]     in_last,
    output logic             out_last
`endif
);

    logic [SEL_W-1:0] ptr;
    logic             load;
    logic [N-1:0]     arb_req;
    logic [SEL_W-1:0] arb_ptr;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic             xfer;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic             locked;
    logic [SEL_W-1:0] lock_idx;
`endif

    assign load = !out_valid || out_ready;

    // Shape the request vector seen by the arbiter: a held lock overrides the
    // mode; fixed mode narrows to the selected channel (out-of-range sel masks all).
    always_comb begin
        arb_req = '0;
        arb_ptr = ptr;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (locked) begin
            arb_req[lock_idx] = in_valid[lock_idx];
            arb_ptr           = lock_idx;
        end else
`endif
        if (mode == MODE_RR) begin
            arb_req = in_valid;
        end else if (int'(sel) < N) begin
            arb_req[sel] = in_valid[sel];
            arb_ptr      = sel;
        end
    end

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .req     (arb_req),
        .ptr     (arb_ptr),
        .en      (load),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // The grant is already qualified by load and in_valid, so it is the ready.
    assign in_ready = gnt;
    assign xfer     = |gnt;

    // Round-robin pointer moves just past the winner; frozen in fixed mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (xfer && mode == MODE_RR) begin
            ptr <= (gnt_idx == SEL_W'(N-1)) ? '0 : gnt_idx + SEL_W'(1);
        end
    end

    // Output register: load on transfer, drop valid on a drain, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[gnt_idx*W +: W];
            out_sel   <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    // Packet lock: engage on a non-last beat, release on the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked   <= 1'b0;
            lock_idx <= '0;
            out_last <= 1'b0;
        end else if (xfer) begin
            locked   <= !in_last[gnt_idx];
            lock_idx <= gnt_idx;
            out_last <= in_last[gnt_idx];
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr (N=5, W=8). Expected beats are queued
// as stimulus is applied and popped whenever the output handshake completes.
module tb_stream_mux_rr;

    localparam int N  = 5;
    localparam int W  = 8;
    localparam int SW = 3;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [SW-1:0] sel;
        logic          last;
    } beat_t;

    logic           clk;
    logic           rst;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_sel;
    logic [N-1:0]   in_last;
    logic           out_last;

    beat_t sb[$];
    beat_t mon_e;
    int    n_cmp;
    int    n_err;

    stream_mux_rr #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
`ifdef STREAM_MUX_PKT_LOCK_EN
        ,
        .in_last   (in_last),
        .out_last  (out_last)
`endif
    );

`ifndef STREAM_MUX_PKT_LOCK_EN
    assign out_last = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d, input logic [SW-1:0] s, input logic l);
        beat_t b;
        b.data = d;
        b.sel  = s;
        b.last = l;
        sb.push_back(b);
    endtask

    task automatic set_ch(input int i, input logic [W-1:0] d);
        in_data[i*W +: W] = d;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        for (int c = 0; c < max_cyc; c++) begin
            if (sb.size() == 0) break;
            tick();
        end
        tick();
        chk("drain_left", 32'(sb.size()), 0);
    endtask

    // Output monitor: every completed output handshake must match the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_beat", 32'(sb.size()), 1);
            end else begin
                mon_e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(mon_e.data));
                chk("out_sel", 32'(out_sel), 32'(mon_e.sel));
`ifdef STREAM_MUX_PKT_LOCK_EN
                chk("out_last", 32'(out_last), 32'(mon_e.last));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        mode      = 1'b0;
        sel       = '0;
        in_data   = '0;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_sel", 32'(out_sel), 0);

        // Reset mid-stream: capture 0xAA on ch0, stall, then reset over it.
        tick();
        set_ch(0, 8'hAA);
        in_valid = 5'b00001;
        tick();
        in_valid = '0;
        @(negedge clk);
        chk("mid_valid", 32'(out_valid), 1);
        chk("mid_data", 32'(out_data), 32'h0AA);
        tick();
        tick();
        chk("mid_hold", 32'(out_data), 32'h0AA);
        do_reset();
        @(negedge clk);
        chk("rst2_valid", 32'(out_valid), 0);
        chk("rst2_data", 32'(out_data), 0);
        chk("rst2_sel", 32'(out_sel), 0);
        tick();

        // Round-robin fairness and wrap with every channel requesting.
        for (int i = 0; i < N; i++) set_ch(i, 8'hA0 + 8'(i));
        mode      = 1'b0;
        out_ready = 1'b1;
        in_valid  = 5'b11111;
        for (int k = 0; k < 7; k++) push(8'hA0 + 8'(k % N), SW'(k % N), 1'b0);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("rr_valid_high", 32'(out_valid), 1);
        end
        in_valid = '0;
        drain(10);

        // Sparse round-robin: only ch1 and ch4 request.
        do_reset();
        set_ch(1, 8'h11);
        set_ch(4, 8'h44);
        in_valid = 5'b10010;
        push(8'h11, 3'd1, 1'b0);
        push(8'h44, 3'd4, 1'b0);
        push(8'h11, 3'd1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("sparse_ready_mask", 32'(in_ready & 5'b01101), 0);
            tick();
        end
        in_valid = '0;
        drain(10);

        // Backpressure: ch2 beat held through a three-cycle stall.
        set_ch(2, 8'h22);
        out_ready = 1'b0;
        in_valid  = 5'b00100;
        push(8'h22, 3'd2, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready", 32'(in_ready), 0);
            chk("bp_data", 32'(out_data), 32'h022);
            chk("bp_valid", 32'(out_valid), 1);
            tick();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_single_beat", 32'(out_valid), 0);
        tick();

        // Fixed select of ch3, then an out-of-range select.
        for (int i = 0; i < N; i++) set_ch(i, 8'hA0 + 8'(i));
        mode     = 1'b1;
        sel      = 3'd3;
        in_valid = 5'b11111;
        for (int k = 0; k < 3; k++) push(8'hA3, 3'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("fixed_ready", 32'(in_ready), 32'h08);
            tick();
        end
        sel = 3'd7;
        @(negedge clk);
        chk("oor_ready", 32'(in_ready), 0);
        tick();
        @(negedge clk);
        chk("oor_drained", 32'(out_valid), 0);
        chk("oor_ready2", 32'(in_ready), 0);
        in_valid = '0;
        mode     = 1'b0;
        sel      = '0;
        tick();

`ifdef STREAM_MUX_PKT_LOCK_EN
        // Packet lock: ch0 three-beat packet holds off ch1 until its last beat.
        do_reset();
        set_ch(1, 8'hB1);
        in_valid = 5'b00011;
        in_last  = 5'b00010;
        push(8'hC0, 3'd0, 1'b0);
        push(8'hC1, 3'd0, 1'b0);
        push(8'hC2, 3'd0, 1'b1);
        push(8'hB1, 3'd1, 1'b1);
        for (int b = 0; b < 3; b++) begin
            set_ch(0, 8'hC0 + 8'(b));
            in_last[0] = (b == 2);
            @(negedge clk);
            chk("lock_ready", 32'(in_ready), 32'h01);
            tick();
        end
        in_valid = 5'b00010;
        in_last  = 5'b00010;
        @(negedge clk);
        chk("lock_release_ready", 32'(in_ready), 32'h02);
        tick();
        in_valid = '0;
        in_last  = '0;
        drain(10);
`endif

        chk("sb_left", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- N-channel, W-bit streaming multiplexer with a valid/ready handshake on every input and on the single output. Generalises the plain N:1 bit mux.
- Two modes:
  - Round-robin arbitration across all channels.
  - Fixed selection via a `sel` port, as in the plain mux.
- Output is registered, with one cycle of latency.
- Sits between multi-source producers and a single shared consumer, such as a bus or a FIFO.

Parameters:
- N, 5, number of input channels (N ≥ 2).
- W, 8, data width per channel.
- SEL_W, $clog2(N), width of the channel index.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = round-robin, 1 = fixed select.
- sel  in  SEL_W  channel index used when mode = 1.
- in_data  in  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; combinational.
- out_data  out  W  registered output data.
- out_valid  out  1  registered output valid.
- out_ready  in  1  consumer ready.
- out_sel  out  SEL_W  index of the channel that supplied out_data; registered.

Behaviour:
- Reset (rst high at a clk edge):
  - out_valid = 0, out_data = 0, out_sel = 0, round-robin pointer ptr = 0.
  - rst overrides every other event in that cycle. Any beat in flight is dropped.
- Load condition: load = !out_valid || out_ready. The output register can take a new beat this cycle.
- Grant (combinational, one-hot or zero):
  - mode 0: the first channel with in_valid set, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wraps modulo N).
  - mode 1: channel sel, if sel < N and in_valid[sel] = 1. sel ≥ N grants nothing and is never an error.
  - No valid candidate means no grant.
- in_ready[i] = load && grant[i]. At most one bit of in_ready is set in any cycle.
- Transfer on input i: in_valid[i] && in_ready[i].
  - Next edge: out_data ← channel i data, out_sel ← i, out_valid ← 1.
  - Latency from acceptance to output: 1 cycle.
- Drain with no new grant: out_valid && out_ready with no input transfer → out_valid ← 0. out_data and out_sel hold their values.
- Stall: out_valid && !out_ready → out_data, out_sel and out_valid hold. in_ready = 0 on all channels.
- Simultaneous drain and accept: full throughput, one beat per cycle, with no bubble.
- Pointer update:
  - On each transfer in mode 0: ptr ← (g+1) mod N, where g is the granted index. g = N-1 wraps ptr to 0.
  - ptr holds in mode 1 and whenever no transfer occurs.
- Mode or sel changes take effect on the next grant evaluation. A beat already in the output register is unaffected.
- Protocol invariants:
  - out_data and out_sel are stable while out_valid && !out_ready.
  - Requesters may deassert in_valid before being accepted; the block never captures data without a transfer.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- When defined:
  - Adds input port in_last (N bits) and output out_last (1 bit, registered, reset 0).
  - out_last carries the last flag of the accepted beat.
  - After a transfer from channel g with in_last[g] = 0, the grant locks to g, ignoring mode, sel and ptr. The lock releases on the transfer where in_last[g] = 1; ptr then advances as normal.
  - While locked, other channels receive in_ready = 0 even if channel g is idle.
  - rst clears the lock.
- When undefined: no last ports, and arbitration happens independently on every beat.

Decomposition:
- Package stream_mux_pkg:
  - mode constants MODE_RR = 1'b0 and MODE_FIXED = 1'b1.
  - a function returning the one-hot to index encoding.
- Sub-module rr_arbiter (parameter N):
  - inputs: req[N], ptr, en.
  - outputs: one-hot gnt and gnt_idx.
  - purely combinational; instantiated once.
- The top level holds ptr, the output register, the lock and the mode/sel logic.

Test Plan (N = 5, W = 8):
- Reset mid-stream: out_valid = 1 holding 0xAA with out_ready = 0; assert rst for 1 cycle → out_valid = 0, out_data = 0, out_sel = 0, ptr = 0.
- Round-robin fairness and wrap: mode 0, all in_valid = 5'b11111, out_ready = 1 constantly → out_sel sequence 0,1,2,3,4,0,1; out_valid continuously high after the first cycle.
- Sparse round-robin: in_valid = 5'b10010 with data ch1 = 0x11, ch4 = 0x44 → outputs 0x11 (sel 1), 0x44 (sel 4), 0x11 (sel 1); in_ready never set for channels 0, 2, 3.
- Backpressure: out_ready = 0 for 3 cycles with ch2 valid (0x22) → 0x22 is held stable; in_ready = 0 during the stall; exactly one 0x22 beat after out_ready = 1.
- Fixed mode and out-of-range sel: mode 1, sel = 3, all channels valid → only ch3 is accepted. sel = 7 → in_ready = 0 and out_valid drops after draining.
- With STREAM_MUX_PKT_LOCK_EN defined: ch0 sends 3 beats with last on the 3rd while ch1 is valid → out_sel = 0,0,0, then 1; ch1 is not granted mid-packet.
